seg7_scan: RTL and testbench
============================

# seg7_scan

Display back-end for the 4-digit BCD counter. It watches the counter's multiplexed nibble/select outputs, debounces them and writes each nibble into a 4-slot digit store. It then autonomously scans a common-anode 4-digit 7-segment display, with an inter-digit blanking gap and optional leading-zero suppression. It is the stage directly downstream of the counter CPLD's p12/p10/p8/p6 (nibble) and p16/p14 (select) pins.

## Interface
- REFRESH_DIV, 4000, f4m cycles each digit is lit (1 ms at 4 MHz).
- BLANK_CYC, 40, f4m cycles all anodes are off between digits; must be ≥1.
- STABLE_CYC, 4, consecutive equal synchronized samples required before a write; must be ≥1.
- f4m  input  1  system clock; single clock domain, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  4  digit nibble from the counter, {p12,p10,p8,p6}; asynchronous to f4m.
- dsel  input  2  slot select from the counter, {p16,p14}; 0 = most significant digit; asynchronous.
- frz  input  1  1 = digit store holds and ignores writes; synchronous level.
- lzb  input  1  1 = leading-zero blanking enabled; synchronous level.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  4  anode enables, active-low; an[0] = leftmost = slot 0.

## Operation
- Capture path:
  - {dsel,din} passes through a 2-flop synchronizer to s2, then one more register to prev.
  - stab counter resets to 0 whenever s2≠prev, else increments, saturating at STABLE_CYC.
  - When stab==STABLE_CYC and frz==0, digit[s2.dsel] ← s2.din. The write repeats every cycle while the input is stable (idempotent).
  - A pattern that holds for fewer than STABLE_CYC+1 synchronized cycles is never written.
- Digit store: four 4-bit registers, all 0 on reset. frz affects writes only; scanning continues.
- Decode at SHOW entry:
  - Values 0–9 map to standard glyphs (0 → 7'b1000000, 8 → 7'b0000000).
  - Values 10–15 show "-" (7'b0111111) as an error indicator.
- Leading-zero blanking: with lzb=1, slot k (k<3) is blank (seg=7'h7F) when digit[0..k] are all 0. Slot 3 is always shown.
- Scan FSM, two states:
  - BLANK: an=4'hF, seg=7'h7F; lasts BLANK_CYC cycles, then moves to SHOW for idx.
  - SHOW: an has only bit idx low; seg is the registered glyph; lasts REFRESH_DIV cycles, then idx←idx+1 (mod 4) and the FSM moves to BLANK.
- seg and blank status are latched on the BLANK→SHOW edge. Writes or lzb changes during SHOW appear at that slot's next SHOW.

## Timing
- Reset (asynchronous, mid-operation included): FSM=BLANK, idx=0, timer=0, an=4'hF, seg=7'h7F, digits=0, sync/prev=0, stab=0. Outputs take these values immediately while rst_n=0.
- After rst_n deasserts, the first SHOW (slot 0) begins on the BLANK_CYC-th rising edge.
- Frame period: 4×(REFRESH_DIV+BLANK_CYC) cycles, 16160 at defaults. No two anodes are ever low together.
- Capture latency: an input change held steady is written on the (STABLE_CYC+3)-th rising edge after it is sampled by the first synchronizer flop.
- Outputs are registered; no combinational path from input to output.
- Timer and idx wrap naturally; idx 3→0.
- A write to the slot currently in SHOW does not glitch seg.

## Test plan
- Reset then free-run, digits=0, lzb=0: an cycles 1110→1111→1101→1111→1011→1111→0111 with dwell 4000/40 cycles; seg=1000000 in every SHOW.
- Drive dsel=0..3 with din=1,2,3,4, each held 50 cycles: next frame shows glyphs 1,2,3,4 on slots 0..3.
- Glitch: dsel=2/din=7 held 3 cycles (< STABLE_CYC+1), then back: digit[2] unchanged. The same pattern held 6 cycles is written on edge 7.
- Digits 0,0,5,0 with lzb=1: slots 0,1 blank, slot 2 shows 5, slot 3 shows 0. Digits 0,0,0,0: only slot 3 lit, showing 0.
- din=4'hC to slot 1: slot 1 shows 0111111. frz=1 then din=3 to slot 1: display keeps showing "-".
- rst_n pulsed low during a SHOW: an=4'hF and seg=7'h7F immediately; digits cleared; restart timing identical to the post-reset case.

Source files
------------

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: bundle between the counter side and the display back-end.
//   din  [3:0]  digit nibble from the counter (asynchronous)
//   dsel [1:0]  slot select, 0 = most significant digit (asynchronous)
//   frz         1 = digit store ignores writes (synchronous level)
//   lzb         1 = leading-zero blanking (synchronous level)
//   seg  [6:0]  segments {g,f,e,d,c,b,a}, active-low
//   an   [3:0]  anode enables, active-low, an[0] = leftmost
interface seg7_scan_if;
  logic [3:0] din;
  logic [1:0] dsel;
  logic       frz;
  logic       lzb;
  logic [6:0] seg;
  logic [3:0] an;

  modport master (output din, dsel, frz, lzb, input seg, an);
  modport slave  (input din, dsel, frz, lzb, output seg, an);
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: captures the counter's multiplexed nibble/select pair into a
// 4-slot digit store after synchronizing and debouncing it, then scans a
// common-anode 4-digit 7-segment display with a blanking gap between digits
// and optional leading-zero suppression.
//   f4m    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    seg7_scan_if.slave (din/dsel/frz/lzb in, seg/an out)

// One digit slot of the store.
module seg7_slot (
  input  logic       f4m,
  input  logic       rst_n,
  input  logic       wr,
  input  logic [3:0] wdat,
  output logic [3:0] val
);
  always_ff @(posedge f4m or negedge rst_n) begin
    if (!rst_n)  val <= '0;
    else if (wr) val <= wdat;
  end
endmodule

module seg7_scan #(
  parameter int REFRESH_DIV = 4000,
  parameter int BLANK_CYC   = 40,
  parameter int STABLE_CYC  = 4
) (
  input logic        f4m,
  input logic        rst_n,
  seg7_scan_if.slave bus
);
  localparam int NUM_DIGITS = 4;
  localparam int TMAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = $clog2(STABLE_CYC + 1);
  localparam logic [TW-1:0] SHOW_LAST  = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);
  localparam logic [SW-1:0] STAB_MAX   = SW'(STABLE_CYC);

  typedef struct packed {
    logic [1:0] dsel;
    logic [3:0] din;
  } cap_t;

  typedef enum logic {BLANK, SHOW} state_t;

  // ---------------- capture path ----------------
  cap_t          s1, s2, prev;
  logic [SW-1:0] stab;
  logic          wr_en;
  logic [NUM_DIGITS-1:0] wr;

  always_ff @(posedge f4m or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
      stab <= '0;
    end else begin
      s1   <= {bus.dsel, bus.din};
      s2   <= s1;
      prev <= s2;
      if (s2 != prev)           stab <= '0;
      else if (stab != STAB_MAX) stab <= stab + 1'b1;
    end
  end

  // stab is one cycle behind s2; the s2==prev term stops a saturated count
  // left over from the previous pattern from committing a freshly changed s2.
  assign wr_en = (stab == STAB_MAX) && (s2 == prev) && !bus.frz;

  always_comb begin
    wr          = '0;
    wr[s2.dsel] = wr_en;
  end

  // ---------------- digit store ----------------
  logic [NUM_DIGITS-1:0][3:0] digit;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_slot
    seg7_slot u_slot (
      .f4m  (f4m),
      .rst_n(rst_n),
      .wr   (wr[g]),
      .wdat (s2.din),
      .val  (digit[g])
    );
  end

  // ---------------- decode ----------------
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b0111111;  // non-BCD value: show "-"
    endcase
  endfunction

  logic [1:0]            idx;
  logic [NUM_DIGITS-1:0] lz_run;   // lz_run[k]: digits 0..k are all zero
  logic                  blank_nxt;
  logic [6:0]            seg_nxt;

  always_comb begin
    lz_run[0] = (digit[0] == 4'd0);
    for (int k = 1; k < NUM_DIGITS; k++)
      lz_run[k] = lz_run[k-1] && (digit[k] == 4'd0);
  end

  // The last slot is never suppressed so a zero count still shows "0".
  assign blank_nxt = bus.lzb && (idx != 2'd3) && lz_run[idx];
  assign seg_nxt   = blank_nxt ? 7'h7F : glyph(digit[idx]);

  // ---------------- scan FSM ----------------
  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    an_r;
  logic [6:0]    seg_r;

  // seg is latched only on BLANK->SHOW, so store writes and lzb changes
  // made while a slot is lit take effect on that slot's next SHOW.
  always_ff @(posedge f4m or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
      idx   <= '0;
      timer <= '0;
      an_r  <= 4'hF;
      seg_r <= 7'h7F;
    end else begin
      case (state)
        BLANK: begin
          if (timer == BLANK_LAST) begin
            timer <= '0;
            state <= SHOW;
            an_r  <= ~(4'b0001 << idx);
            seg_r <= seg_nxt;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SHOW: begin
          if (timer == SHOW_LAST) begin
            timer <= '0;
            state <= BLANK;
            idx   <= idx + 1'b1;
            an_r  <= 4'hF;
            seg_r <= 7'h7F;
          end else begin
            timer <= timer + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.an  = an_r;
  assign bus.seg = seg_r;
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: drives seg7_scan through the interface with directed and
// randomized capture patterns and checks the display against a closed-form
// timing model plus a digit-store model built from the capture rules.
// Timing parameters are scaled down so many frames fit in a short run.
module tb_seg7_scan;
  localparam int RD = 400;
  localparam int BC = 8;
  localparam int SC = 4;
  localparam int P  = RD + BC;
  localparam int FR = 4 * P;
  localparam logic [6:0] GLY [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic f4m = 1'b0;
  logic rst_n = 1'b0;
  seg7_scan_if bus();

  seg7_scan #(.REFRESH_DIV(RD), .BLANK_CYC(BC), .STABLE_CYC(SC)) dut (
    .f4m  (f4m),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 f4m = ~f4m;

  int checks = 0;
  int failures = 0;
  int ncyc;                 // rising edges since reset released
  logic [3:0] exp_dig [4];  // model of the digit store

  always @(posedge f4m or negedge rst_n)
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;

  function automatic logic [6:0] exp_glyph(input int k);
    logic allz;
    allz = 1'b1;
    for (int j = 0; j <= k; j++) if (exp_dig[j] != 4'd0) allz = 1'b0;
    if (bus.lzb && k < 3 && allz) return 7'h7F;
    if (exp_dig[k] < 4'd10) return GLY[exp_dig[k]];
    return 7'h3F;
  endfunction

  function automatic logic [3:0] exp_an(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << k);
  endfunction

  // Expected outputs after edge n: each slot period is BC blank then RD lit.
  function automatic void model_out(input int n, output logic [3:0] ean,
                                    output logic [6:0] eseg);
    int m;
    m = n % FR;
    if ((m % P) < BC) begin
      ean = 4'hF; eseg = 7'h7F;
    end else begin
      ean = exp_an(m / P); eseg = exp_glyph(m / P);
    end
  endfunction

  // Pattern sampled by exactly 'hold' rising edges; a hold of SC+2 or more
  // is committed, SC or fewer never is.
  task automatic drive(input logic [1:0] s, input logic [3:0] d, input int hold);
    @(negedge f4m);
    bus.dsel = s;
    bus.din  = d;
    repeat (hold - 1) @(negedge f4m);
    if (hold >= SC + 2 && !bus.frz) exp_dig[s] = d;
  endtask

  // Park on the first negedge of slot k's next SHOW (always within a frame).
  task automatic wait_show(input int k);
    for (int i = 0; i <= FR; i++) begin
      @(negedge f4m);
      if ((ncyc % FR) / P == k && (ncyc % FR) % P == BC) break;
    end
  endtask

  task automatic test_reset;
    bus.din = 4'd0; bus.dsel = 2'd0; bus.frz = 1'b0; bus.lzb = 1'b0;
    for (int i = 0; i < 4; i++) exp_dig[i] = 4'd0;
    rst_n = 1'b0;
    #23;
    checks++;
    if (bus.an !== 4'hF) begin
      failures++; $display("FAIL reset_an got=%b want=1111", bus.an);
    end
    checks++;
    if (bus.seg !== 7'h7F) begin
      failures++; $display("FAIL reset_seg got=%b want=1111111", bus.seg);
    end
    @(negedge f4m);
    rst_n = 1'b1;
  endtask

  task automatic test_free_run;
    logic [3:0] ean; logic [6:0] eseg;
    for (int i = 0; i < FR + BC + 2; i++) begin
      @(negedge f4m);
      model_out(ncyc, ean, eseg);
      checks++;
      if ({bus.an, bus.seg} !== {ean, eseg}) begin
        failures++;
        $display("FAIL free_run n=%0d an=%b seg=%b want an=%b seg=%b",
                 ncyc, bus.an, bus.seg, ean, eseg);
      end
    end
  endtask

  task automatic test_write_digits;
    for (int k = 0; k < 4; k++) drive(2'(k), 4'(k + 1), 50);
    repeat (10) @(negedge f4m);
    for (int k = 0; k < 4; k++) begin
      wait_show(k);
      checks++;
      if (bus.an !== exp_an(k) || bus.seg !== GLY[k + 1]) begin
        failures++;
        $display("FAIL write_digits slot=%0d an=%b seg=%b want an=%b seg=%b",
                 k, bus.an, bus.seg, exp_an(k), GLY[k + 1]);
      end
    end
  endtask

  task automatic test_glitch;
    drive(2'd2, 4'd7, 3);
    drive(2'd3, 4'd4, 20);
    wait_show(2);
    checks++;
    if (bus.seg !== GLY[3]) begin
      failures++; $display("FAIL glitch_short seg=%b want=%b", bus.seg, GLY[3]);
    end
    drive(2'd2, 4'd7, 6);
    drive(2'd3, 4'd4, 20);
    wait_show(2);
    checks++;
    if (bus.seg !== GLY[7]) begin
      failures++; $display("FAIL glitch_long seg=%b want=%b", bus.seg, GLY[7]);
    end
  endtask

  task automatic test_lzb;
    logic [6:0] want [4];
    @(negedge f4m); bus.lzb = 1'b1;
    drive(2'd0, 4'd0, 10); drive(2'd1, 4'd0, 10);
    drive(2'd2, 4'd5, 10); drive(2'd3, 4'd0, 10);
    repeat (10) @(negedge f4m);
    want = '{7'h7F, 7'h7F, GLY[5], GLY[0]};
    for (int k = 0; k < 4; k++) begin
      wait_show(k);
      checks++;
      if (bus.an !== exp_an(k) || bus.seg !== want[k]) begin
        failures++;
        $display("FAIL lzb_0050 slot=%0d an=%b seg=%b want an=%b seg=%b",
                 k, bus.an, bus.seg, exp_an(k), want[k]);
      end
    end
    drive(2'd2, 4'd0, 10);
    repeat (10) @(negedge f4m);
    want = '{7'h7F, 7'h7F, 7'h7F, GLY[0]};
    for (int k = 0; k < 4; k++) begin
      wait_show(k);
      checks++;
      if (bus.seg !== want[k]) begin
        failures++;
        $display("FAIL lzb_0000 slot=%0d seg=%b want=%b", k, bus.seg, want[k]);
      end
    end
    @(negedge f4m); bus.lzb = 1'b0;
  endtask

  task automatic test_error_frz;
    drive(2'd1, 4'hC, 20);
    repeat (10) @(negedge f4m);
    wait_show(1);
    checks++;
    if (bus.seg !== 7'h3F) begin
      failures++; $display("FAIL error_glyph seg=%b want=0111111", bus.seg);
    end
    @(negedge f4m); bus.frz = 1'b1;
    drive(2'd1, 4'd3, 20);
    repeat (10) @(negedge f4m);
    wait_show(1);
    checks++;
    if (bus.seg !== 7'h3F) begin
      failures++; $display("FAIL frz_hold seg=%b want=0111111", bus.seg);
    end
    // Releasing freeze commits the pattern still sitting on the bus.
    @(negedge f4m); bus.frz = 1'b0;
    exp_dig[bus.dsel] = bus.din;
    repeat (10) @(negedge f4m);
    wait_show(1);
    checks++;
    if (bus.seg !== GLY[3]) begin
      failures++; $display("FAIL frz_release seg=%b want=%b", bus.seg, GLY[3]);
    end
  endtask

  task automatic test_no_glitch;
    logic [6:0] held;
    logic [3:0] nv;
    wait_show(2);
    held = exp_glyph(2);
    nv = (exp_dig[2] == 4'd5) ? 4'd8 : 4'd5;
    @(negedge f4m);
    bus.dsel = 2'd2; bus.din = nv;
    for (int j = 0; j < 20; j++) begin
      @(negedge f4m);
      checks++;
      if (bus.seg !== held || bus.an !== exp_an(2)) begin
        failures++;
        $display("FAIL no_glitch cyc=%0d an=%b seg=%b want an=%b seg=%b",
                 j, bus.an, bus.seg, exp_an(2), held);
      end
    end
    exp_dig[2] = nv;
    wait_show(2);
    checks++;
    if (bus.seg !== GLY[nv]) begin
      failures++; $display("FAIL no_glitch_next seg=%b want=%b", bus.seg, GLY[nv]);
    end
  endtask

  task automatic test_random;
    logic [3:0] v;
    logic [6:0] w;
    for (int it = 0; it < 4; it++) begin
      @(negedge f4m); bus.lzb = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 1) == 1)
          drive(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                $urandom_range(1, SC));
        v = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        drive(2'(k), v, $urandom_range(SC + 2, 30));
      end
      repeat (10) @(negedge f4m);
      for (int k = 0; k < 4; k++) begin
        wait_show(k);
        w = exp_glyph(k);
        checks++;
        if (bus.an !== exp_an(k) || bus.seg !== w) begin
          failures++;
          $display("FAIL random it=%0d slot=%0d an=%b seg=%b want an=%b seg=%b",
                   it, k, bus.an, bus.seg, exp_an(k), w);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] ean; logic [6:0] eseg;
    @(negedge f4m); bus.lzb = 1'b0;
    drive(2'd0, 4'd9, 10); drive(2'd1, 4'd6, 10);
    drive(2'd3, 4'd0, 20);
    wait_show(1);
    repeat (50) @(negedge f4m);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin
      failures++;
      $display("FAIL reset_mid an=%b seg=%b want an=1111 seg=1111111",
               bus.an, bus.seg);
    end
    for (int i = 0; i < 4; i++) exp_dig[i] = 4'd0;
    repeat (3) @(negedge f4m);
    rst_n = 1'b1;
    for (int i = 0; i < FR + BC + 2; i++) begin
      @(negedge f4m);
      model_out(ncyc, ean, eseg);
      checks++;
      if ({bus.an, bus.seg} !== {ean, eseg}) begin
        failures++;
        $display("FAIL restart n=%0d an=%b seg=%b want an=%b seg=%b",
                 ncyc, bus.an, bus.seg, ean, eseg);
      end
    end
  endtask

  initial begin
    test_reset;
    test_free_run;
    test_write_digits;
    test_glitch;
    test_lzb;
    test_error_frz;
    test_no_glitch;
    test_random;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
